// File: rtl/region_check_pkg.sv
// Shared types for the region-check custom-function unit: op codes, FSM states
// and the region record presented by the table to the comparator.
package region_check_pkg;

  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    OP_SET_MIN    = 3'd0,
    OP_SET_MAX    = 3'd1,
    OP_QUERY      = 3'd2,
    OP_READ_COUNT = 3'd3,
    OP_CLEAR_ALL  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  // Coordinates are sign-extended to 32 bits so the record is independent of COORD_W.
  typedef struct packed {
    logic signed [31:0] xmin;
    logic signed [31:0] ymin;
    logic signed [31:0] xmax;
    logic signed [31:0] ymax;
    logic               valid;
  } region_t;

endpackage

// File: rtl/region_check_cfu_if.sv
// CFU command/response bus: the CPU side is the master, the function unit the slave.
interface region_check_cfu_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/region_check_cfu_region_table.sv
// Rectangle table: bounds, valid bits and saturating hit counters, with one
// indexed read port feeding the single shared point-in-box comparator.
module region_table
  import region_check_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int COORD_W     = 16,
  parameter int COUNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IDX_W-1:0]          sel_idx,
  input  logic                      wr_min,
  input  logic                      wr_max,
  input  logic                      clr_all,
  input  logic signed [COORD_W-1:0] wr_x,
  input  logic signed [COORD_W-1:0] wr_y,
  input  logic signed [COORD_W-1:0] pt_x,
  input  logic signed [COORD_W-1:0] pt_y,
  input  logic                      cnt_inc,
  input  logic                      cnt_clr,
  output logic                      hit,
  output logic [COUNT_W-1:0]        cnt_rd
);

  logic signed [COORD_W-1:0] xmin_q [NUM_REGIONS];
  logic signed [COORD_W-1:0] ymin_q [NUM_REGIONS];
  logic signed [COORD_W-1:0] xmax_q [NUM_REGIONS];
  logic signed [COORD_W-1:0] ymax_q [NUM_REGIONS];
  logic signed [COORD_W-1:0] xmin_d [NUM_REGIONS];
  logic signed [COORD_W-1:0] ymin_d [NUM_REGIONS];
  logic signed [COORD_W-1:0] xmax_d [NUM_REGIONS];
  logic signed [COORD_W-1:0] ymax_d [NUM_REGIONS];
  logic [COUNT_W-1:0]        cnt_q  [NUM_REGIONS];
  logic [COUNT_W-1:0]        cnt_d  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0]    valid_q, valid_d;

  region_t            sel_rgn;
  logic signed [31:0] px, py;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (&c) ? c : c + COUNT_W'(1);
  endfunction

  // Indices at or beyond NUM_REGIONS match no entry, so they read as an invalid, zero-count region.
  always_comb begin
    sel_rgn = '0;
    cnt_rd  = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_rgn.xmin  = 32'(xmin_q[i]);
        sel_rgn.ymin  = 32'(ymin_q[i]);
        sel_rgn.xmax  = 32'(xmax_q[i]);
        sel_rgn.ymax  = 32'(ymax_q[i]);
        sel_rgn.valid = valid_q[i];
        cnt_rd        = cnt_q[i];
      end
    end
  end

  assign px  = 32'(pt_x);
  assign py  = 32'(pt_y);
  assign hit = sel_rgn.valid
             && ($signed(sel_rgn.xmin) <= px) && (px < $signed(sel_rgn.xmax))
             && ($signed(sel_rgn.ymin) <= py) && (py < $signed(sel_rgn.ymax));

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      xmin_d[i] = xmin_q[i];
      ymin_d[i] = ymin_q[i];
      xmax_d[i] = xmax_q[i];
      ymax_d[i] = ymax_q[i];
      cnt_d[i]  = cnt_q[i];
      if (sel_idx == IDX_W'(i)) begin
        if (wr_min) begin
          xmin_d[i]  = wr_x;
          ymin_d[i]  = wr_y;
          valid_d[i] = 1'b0;
        end
        if (wr_max) begin
          xmax_d[i]  = wr_x;
          ymax_d[i]  = wr_y;
          valid_d[i] = 1'b1;
        end
        if (cnt_clr) begin
          cnt_d[i] = '0;
        end else if (cnt_inc && hit) begin
          cnt_d[i] = sat_inc(cnt_q[i]);
        end
      end
      if (clr_all) begin
        cnt_d[i] = '0;
      end
    end
    if (clr_all) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        xmin_q[i] <= '0;
        ymin_q[i] <= '0;
        xmax_q[i] <= '0;
        ymax_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        xmin_q[i] <= xmin_d[i];
        ymin_q[i] <= ymin_d[i];
        xmax_q[i] <= xmax_d[i];
        ymax_q[i] <= ymax_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/region_check_cfu.sv
// Region-check CFU: tests a signed point against a rectangle table, one region
// per clock during QUERY, and answers every other command after one clock.
module region_check_cfu
  import region_check_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int COORD_W     = 16,
  parameter int COUNT_W     = 16
) (
  input logic               clk,
  input logic               reset,
  region_check_cfu_if.slave bus
);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          scan_q, scan_d;
  logic [NUM_REGIONS-1:0]    mask_q, mask_d;
  logic [31:0]               rsp_q, rsp_d;
  logic signed [COORD_W-1:0] qx_q, qx_d, qy_q, qy_d;

  logic [2:0]                cmd_op;
  logic [IDX_W-1:0]          cmd_idx;
  logic                      accept, scan_last;
  logic [IDX_W-1:0]          tbl_sel;
  logic                      wr_min, wr_max, clr_all, cnt_inc, cnt_clr;
  logic                      tbl_hit;
  logic [COUNT_W-1:0]        tbl_cnt;
  logic                      unused_fid;

  assign cmd_op     = bus.cmd_payload_function_id[2:0];
  assign cmd_idx    = bus.cmd_payload_function_id[7:3];
  assign accept     = (state_q == IDLE) && bus.cmd_valid;
  assign scan_last  = (scan_q == IDX_W'(NUM_REGIONS - 1));
  assign unused_fid = &{1'b0, bus.cmd_payload_function_id[9:8]};

  if (COORD_W < 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = &{1'b0, bus.cmd_payload_inputs_0[31:COORD_W],
                         bus.cmd_payload_inputs_1[31:COORD_W]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (cmd_op == OP_QUERY) ? SCAN : RESP;
      SCAN:    if (scan_last) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Table writes and count reads happen on the accept edge; during SCAN the scan index owns the read port.
  always_comb begin
    bus.cmd_ready             = (state_q == IDLE);
    bus.rsp_valid             = (state_q == RESP);
    bus.rsp_payload_outputs_0 = rsp_q;
    tbl_sel                   = (state_q == SCAN) ? scan_q : cmd_idx;
    wr_min                    = accept && (cmd_op == OP_SET_MIN);
    wr_max                    = accept && (cmd_op == OP_SET_MAX);
    clr_all                   = accept && (cmd_op == OP_CLEAR_ALL);
    cnt_clr                   = accept && (cmd_op == OP_READ_COUNT) && bus.cmd_payload_inputs_0[0];
    cnt_inc                   = (state_q == SCAN);
  end

  always_comb begin
    scan_d = scan_q;
    mask_d = mask_q;
    rsp_d  = rsp_q;
    qx_d   = qx_q;
    qy_d   = qy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          scan_d = '0;
          mask_d = '0;
          qx_d   = bus.cmd_payload_inputs_0[COORD_W-1:0];
          qy_d   = bus.cmd_payload_inputs_1[COORD_W-1:0];
          rsp_d  = (cmd_op == OP_READ_COUNT) ? 32'(tbl_cnt) : '0;
        end
      end
      SCAN: begin
        scan_d = scan_q + IDX_W'(1);
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if ((scan_q == IDX_W'(i)) && tbl_hit) mask_d[i] = 1'b1;
        end
        if (scan_last) rsp_d = 32'(mask_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q <= '0;
      mask_q <= '0;
      rsp_q  <= '0;
      qx_q   <= '0;
      qy_q   <= '0;
    end else begin
      scan_q <= scan_d;
      mask_q <= mask_d;
      rsp_q  <= rsp_d;
      qx_q   <= qx_d;
      qy_q   <= qy_d;
    end
  end

  region_table #(
    .NUM_REGIONS (NUM_REGIONS),
    .COORD_W     (COORD_W),
    .COUNT_W     (COUNT_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .sel_idx (tbl_sel),
    .wr_min  (wr_min),
    .wr_max  (wr_max),
    .clr_all (clr_all),
    .wr_x    (bus.cmd_payload_inputs_0[COORD_W-1:0]),
    .wr_y    (bus.cmd_payload_inputs_1[COORD_W-1:0]),
    .pt_x    (qx_q),
    .pt_y    (qy_q),
    .cnt_inc (cnt_inc),
    .cnt_clr (cnt_clr),
    .hit     (tbl_hit),
    .cnt_rd  (tbl_cnt)
  );

endmodule

// File: tb/tb_region_check_cfu.sv
// Bench for region_check_cfu: a 16-bit-counter and a 2-bit-counter instance share
// one command stream and are compared against a behavioural region model.
module tb_region_check_cfu;
  import region_check_pkg::*;

  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  region_check_cfu_if bus_a ();
  region_check_cfu_if bus_b ();

  assign bus_b.cmd_valid               = bus_a.cmd_valid;
  assign bus_b.cmd_payload_function_id = bus_a.cmd_payload_function_id;
  assign bus_b.cmd_payload_inputs_0    = bus_a.cmd_payload_inputs_0;
  assign bus_b.cmd_payload_inputs_1    = bus_a.cmd_payload_inputs_1;
  assign bus_b.rsp_ready               = bus_a.rsp_ready;

  region_check_cfu #(.NUM_REGIONS(NR), .COORD_W(16), .COUNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  region_check_cfu #(.NUM_REGIONS(NR), .COORD_W(16), .COUNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer rectangles with unbounded hit counts.
  int m_xmin [NR];
  int m_ymin [NR];
  int m_xmax [NR];
  int m_ymax [NR];
  bit m_val  [NR];
  int m_cnt  [NR];

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic int sx(input logic [31:0] v);
    logic [15:0] lo;
    lo = v[15:0];
    return int'($signed(lo));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_xmin[i] = 0; m_ymin[i] = 0; m_xmax[i] = 0; m_ymax[i] = 0;
      m_val[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [4:0] idx,
                             input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] e16, output logic [31:0] e2);
    int k, x, y;
    k = int'(idx);
    x = sx(a);
    y = sx(b);
    e16 = '0;
    e2  = '0;
    case (op)
      3'd0: if (k < NR) begin m_xmin[k] = x; m_ymin[k] = y; m_val[k] = 1'b0; end
      3'd1: if (k < NR) begin m_xmax[k] = x; m_ymax[k] = y; m_val[k] = 1'b1; end
      3'd2: begin
        for (int i = 0; i < NR; i++) begin
          if (m_val[i] && m_xmin[i] <= x && x < m_xmax[i] && m_ymin[i] <= y && y < m_ymax[i]) begin
            e16[i] = 1'b1;
            m_cnt[i]++;
          end
        end
        e2 = e16;
      end
      3'd3: if (k < NR) begin
        e16 = (m_cnt[k] > 65535) ? 32'd65535 : 32'(m_cnt[k]);
        e2  = (m_cnt[k] > 3) ? 32'd3 : 32'(m_cnt[k]);
        if (a[0]) m_cnt[k] = 0;
      end
      3'd4: for (int i = 0; i < NR; i++) begin m_val[i] = 1'b0; m_cnt[i] = 0; end
      default: ;
    endcase
  endtask

  // One full transaction; hold>0 keeps rsp_ready low that many cycles while a CLEAR_ALL is offered.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] idx,
                        input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [31:0] ra, output logic [31:0] rb);
    logic [31:0] e16, e2;
    int lat, exp_lat;
    exp_lat = (op == 3'd2) ? 1 + NR : 1;
    chk("cmd_ready_idle", 32'(bus_a.cmd_ready), 32'd1);
    bus_a.cmd_payload_function_id = {2'b00, idx, op};
    bus_a.cmd_payload_inputs_0    = a;
    bus_a.cmd_payload_inputs_1    = b;
    bus_a.cmd_valid               = 1'b1;
    bus_a.rsp_ready               = (hold == 0);
    @(posedge clk); #1;
    bus_a.cmd_valid               = 1'b0;
    bus_a.cmd_payload_function_id = 10'($urandom());
    bus_a.cmd_payload_inputs_0    = $urandom();
    bus_a.cmd_payload_inputs_1    = $urandom();
    model_apply(op, idx, a, b, e16, e2);
    lat = 1;
    while (!bus_a.rsp_valid && lat < 40) begin
      chk("cmd_ready_busy", 32'(bus_a.cmd_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_valid_b", 32'(bus_b.rsp_valid), 32'd1);
    ra = bus_a.rsp_payload_outputs_0;
    rb = bus_b.rsp_payload_outputs_0;
    chk("rsp_model_a", ra, e16);
    chk("rsp_model_b", rb, e2);
    if (hold > 0) begin
      bus_a.cmd_payload_function_id = {2'b00, 5'd0, 3'd4};
      bus_a.cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("hold_payload", bus_a.rsp_payload_outputs_0, ra);
        chk("hold_cmd_ready", 32'(bus_a.cmd_ready), 32'd0);
      end
      bus_a.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus_a.cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    chk("rsp_done", 32'(bus_a.rsp_valid | bus_b.rsp_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb, ta, tbv, a, b;
    logic [2:0]  op;
    int          r, cx, cy;

    bus_a.cmd_valid = 1'b0;
    bus_a.cmd_payload_function_id = '0;
    bus_a.cmd_payload_inputs_0 = '0;
    bus_a.cmd_payload_inputs_1 = '0;
    bus_a.rsp_ready = 1'b1;
    model_reset();

    vt[0]  = '{3'd2, 5'd0, 32'h0000_0000, 32'h0000_0000, 32'h0};
    vt[1]  = '{3'd0, 5'd0, 32'h1234_FFF6, 32'hFFFF_FFF6, 32'h0};
    vt[2]  = '{3'd1, 5'd0, 32'h0000_000A, 32'h8000_000A, 32'h0};
    vt[3]  = '{3'd0, 5'd2, 32'h0000_0005, 32'h0000_0005, 32'h0};
    vt[4]  = '{3'd1, 5'd2, 32'h0000_0014, 32'h0000_0014, 32'h0};
    vt[5]  = '{3'd2, 5'd0, 32'h0000_0007, 32'h0000_0007, 32'h5};
    vt[6]  = '{3'd2, 5'd0, 32'h0000_000A, 32'h0000_0009, 32'h4};
    vt[7]  = '{3'd2, 5'd0, 32'hFFFF_FFF6, 32'h5555_FFF6, 32'h1};
    vt[8]  = '{3'd2, 5'd0, 32'h0000_0014, 32'h0000_0005, 32'h0};
    vt[9]  = '{3'd3, 5'd0, 32'h0000_0000, 32'h0000_0000, 32'h2};
    vt[10] = '{3'd3, 5'd2, 32'h0000_0001, 32'h0000_0000, 32'h2};
    vt[11] = '{3'd3, 5'd2, 32'h0000_0000, 32'h0000_0000, 32'h0};

    #12;
    chk("reset_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus_a.rsp_valid | bus_b.rsp_valid), 32'd0);
    chk("reset_payload_a", bus_a.rsp_payload_outputs_0, 32'd0);
    chk("reset_payload_b", bus_b.rsp_payload_outputs_0, 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(bus_a.cmd_ready & bus_b.cmd_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      do_cmd(vt[i].op, vt[i].idx, vt[i].a, vt[i].b, 0, ra, rb);
      chk($sformatf("vec%0d_a", i), ra, vt[i].exp);
      chk($sformatf("vec%0d_b", i), rb, vt[i].exp);
    end

    for (int i = 0; i < 4; i++) do_cmd(3'd2, 5'd0, 32'd0, 32'd0, 0, ra, rb);
    do_cmd(3'd3, 5'd0, 32'd1, 32'd0, 0, ra, rb);
    chk("sat_cnt_w16", ra, 32'd6);
    chk("sat_cnt_w2", rb, 32'd3);

    do_cmd(3'd0, 5'd0, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 0, ra, rb);
    do_cmd(3'd2, 5'd0, 32'd0, 32'd0, 0, ra, rb);
    chk("set_min_invalidates", ra, 32'd0);

    do_cmd(3'd4, 5'd0, 32'd0, 32'd0, 0, ra, rb);
    do_cmd(3'd2, 5'd0, 32'd7, 32'd7, 0, ra, rb);
    chk("clear_all_query", ra, 32'd0);
    do_cmd(3'd3, 5'd2, 32'd0, 32'd0, 0, ra, rb);
    chk("clear_all_count", ra, 32'd0);

    do_cmd(3'd1, 5'd2, 32'd20, 32'd20, 0, ra, rb);
    do_cmd(3'd2, 5'd0, 32'd7, 32'd7, 7, ra, rb);
    chk("hold_query", ra, 32'd4);
    do_cmd(3'd2, 5'd0, 32'd7, 32'd7, 0, ra, rb);
    chk("no_accept_in_hold", ra, 32'd4);
    do_cmd(3'd3, 5'd2, 32'd0, 32'd0, 0, ra, rb);
    chk("count_after_hold", ra, 32'd2);

    do_cmd(3'd0, 5'd9, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 0, ra, rb);
    do_cmd(3'd1, 5'd9, 32'd100, 32'd100, 0, ra, rb);
    do_cmd(3'd3, 5'd9, 32'd0, 32'd0, 0, ra, rb);
    chk("idx9_read", ra, 32'd0);
    do_cmd(3'd2, 5'd0, 32'd0, 32'd0, 0, ra, rb);
    chk("idx9_write_ignored", ra, 32'd0);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 3)       op = 3'd0;
      else if (r < 7)  op = 3'd1;
      else if (r < 14) op = 3'd2;
      else if (r < 17) op = 3'd3;
      else if (r == 17) op = 3'd4;
      else             op = 3'($urandom_range(5, 7));
      cx  = int'($urandom_range(0, 60)) - 30;
      cy  = int'($urandom_range(0, 60)) - 30;
      ta  = $urandom();
      tbv = $urandom();
      a   = {ta[31:16], 16'(cx)};
      b   = {tbv[31:16], 16'(cy)};
      do_cmd(op, 5'($urandom_range(0, 5)), a, b, 0, ra, rb);
    end

    do_cmd(3'd0, 5'd1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, ra, rb);
    do_cmd(3'd1, 5'd1, 32'd16, 32'd16, 0, ra, rb);
    bus_a.cmd_payload_function_id = {2'b00, 5'd0, 3'd2};
    bus_a.cmd_payload_inputs_0 = 32'd0;
    bus_a.cmd_payload_inputs_1 = 32'd0;
    bus_a.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scan2_cmd_ready", 32'(bus_a.cmd_ready), 32'd0);
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("reset_drop_valid", 32'(bus_a.rsp_valid | bus_b.rsp_valid), 32'd0);
    end
    chk("reset_drop_ready", 32'(bus_a.cmd_ready & bus_b.cmd_ready), 32'd1);
    for (int i = 0; i < NR; i++) begin
      do_cmd(3'd3, 5'(i), 32'd0, 32'd0, 0, ra, rb);
      chk($sformatf("reset_cnt%0d", i), ra, 32'd0);
    end
    do_cmd(3'd2, 5'd0, 32'd0, 32'd0, 0, ra, rb);
    chk("reset_query", ra, 32'd0);
    do_cmd(3'd1, 5'd0, 32'd5, 32'd5, 0, ra, rb);
    do_cmd(3'd2, 5'd0, 32'd0, 32'd0, 0, ra, rb);
    chk("reset_min_zero_hit", ra, 32'd1);
    do_cmd(3'd2, 5'd0, 32'hFFFF_FFFF, 32'd0, 0, ra, rb);
    chk("reset_min_zero_miss", ra, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/region_check_cfu.md
Name: region_check_cfu

Overview:
- Custom-function unit on the CPU CFU bus; tests a signed 2-D point against a table of NUM_REGIONS rectangles with arbitrary origin.
- Returns a hit bitmask and keeps a saturating hit counter per region.
- Multi-cycle: QUERY scans one region per clock; all other commands respond after one clock.
- Used by keyword-spotting and vision kernels for bounds and ROI tests.

Parameters:
NUM_REGIONS, 4, number of rectangles; legal range 1..32.
COORD_W, 16, signed coordinate width; taken from the low COORD_W bits of each input.
COUNT_W, 16, hit-counter width; legal range 1..32.

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_payload_function_id  input  10  [2:0] = op; [9:3] = region index (only [7:3] used)
cmd_payload_inputs_0  input  32  x, or op argument
cmd_payload_inputs_1  input  32  y, or op argument
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_payload_outputs_0  output  32  result

Behaviour:
Interface:
- One clock domain (clk). Reset is asynchronous and active-high.

Reset:
- State goes to IDLE; cmd_ready=1, rsp_valid=0, rsp_payload_outputs_0=0.
- All region bounds, valid bits and counters are cleared to 0.
- Reset during SCAN or RESP drops the transaction; no response is issued.

States:
- IDLE: cmd_ready=1. On accept, latch op, index and inputs. QUERY goes to SCAN; all other ops go to RESP.
- SCAN: cmd_ready=0. Region i is evaluated on scan cycle i (i=0..NUM_REGIONS-1), setting mask bit i and incrementing counter i on a hit. After NUM_REGIONS cycles, go to RESP.
- RESP: rsp_valid=1 and payload is held stable until rsp_ready, then go to IDLE.
- rsp_valid stays high while rsp_ready=0; nothing is accepted in that time. There is no back-to-back accept in the RESP->IDLE cycle.

Latency (command accepted in cycle N):
- Non-QUERY: rsp_valid in cycle N+1.
- QUERY: rsp_valid in cycle N+1+NUM_REGIONS.

Ops (function_id[2:0]):
- 0 SET_MIN: region[idx].xmin=in0, ymin=in1; clears the valid bit; response 0.
- 1 SET_MAX: region[idx].xmax=in0, ymax=in1; sets the valid bit; response 0.
- 2 QUERY: point (in0,in1).
  - Hit = valid && xmin<=x<xmax && ymin<=y<ymax, compared as signed COORD_W.
  - Response is the zero-extended NUM_REGIONS-bit mask.
  - Counter i increments on a hit and saturates at 2^COUNT_W-1.
- 3 READ_COUNT: returns zero-extended counter[idx]; if in0[0]=1 the counter clears as the response is registered.
- 4 CLEAR_ALL: clears all valid bits and counters (bounds are kept); response 0.
- 5..7: no state change; response 0.

Boundary conditions:
- idx >= NUM_REGIONS: writes are ignored; reads return 0.
- Empty or inverted box (xmax<=xmin or ymax<=ymin) never hits.
- Points on the max edge miss; points on the min edge hit.
- Upper input bits above COORD_W are ignored; no overflow handling is needed.
- cmd payload is sampled only at accept and may change afterwards.

Decomposition:
- Package region_check_pkg holds:
  - op codes (OP_SET_MIN..OP_CLEAR_ALL);
  - state enum (IDLE, SCAN, RESP);
  - a region record type (xmin, ymin, xmax, ymax, valid).
- One sub-module, region_table: bounds storage, valid bits, counters with saturation and clear, and the indexed read mux feeding a single shared comparator.
- Top level: FSM, scan index counter, mask register, response register.

Test Plan:
- Reset, then QUERY (0,0) -> rsp_valid exactly 5 cycles after accept (NUM_REGIONS=4); payload 0; cmd_ready low during the scan.
- Region 0 = [-10,-10)..(10,10); region 2 = [5,5)..(20,20); QUERY (7,7) -> 0x5; QUERY (10,9) -> 0x4; QUERY (-10,-10) -> 0x1; QUERY (20,5) -> 0x0.
- After the above: READ_COUNT idx0 in0=0 -> 2; READ_COUNT idx2 in0=1 -> 2, then READ_COUNT idx2 -> 0.
- COUNT_W=2: four hits on region 0, READ_COUNT -> 3 (saturated). SET_MIN idx0 then QUERY -> bit0 clear. CLEAR_ALL -> all queries 0 and all counters 0.
- Hold rsp_ready=0 for 7 cycles during RESP -> payload and rsp_valid stable, cmd_ready=0. Write to idx 9 -> ignored; READ_COUNT idx9 -> 0.
- Assert reset in scan cycle 2 -> rsp_valid never rises; cmd_ready=1 after reset; table and counters read 0.
